cyber_threshold_tuner: RTL and testbench

Adaptive-difficulty block that runs the opposite way to the cyber player. It observes human press pulses and round outcomes, and produces the threshold that the cyber player consumes. The threshold is set so that a larger value means a more aggressive cyber player. The block sits in the clk_game domain between the human edge-pulse path and scoreboard outputs on one side and the cyber_player threshold input on the other. The top level selects between this output and the switch value.

---
 rtl/cyber_threshold_tuner.sv | 198 +++++++++++++++++++
 tb/tb_cyber_threshold_tuner.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cyber_threshold_tuner.sv
// Adaptive difficulty tuner: measures human press rate over a fixed window and
// slews the cyber player's aggression threshold toward a press-derived target,
// nudged by the most recent round outcome.
module cyber_threshold_tuner #(
  parameter int unsigned WINDOW_POW  = 10,
  parameter int unsigned THRESH_W    = 10,
  parameter int unsigned INIT_THRESH = 128,
  parameter int unsigned SCALE_POW   = 3,
  parameter int unsigned STEP        = 16,
  parameter int unsigned BIAS        = 32,
  parameter int unsigned MIN_THRESH  = 16,
  parameter int unsigned MAX_THRESH  = 511
) (
  input  logic                clk_game,
  input  logic                reset,
  input  logic                enable,
  input  logic                press,
  input  logic                done,
  input  logic [1:0]          winner,
  input  logic                manual_load,
  input  logic [THRESH_W-1:0] manual_thresh,
  output logic [THRESH_W-1:0] threshold,
  output logic                updated,
  output logic [7:0]          last_count
);

  localparam int unsigned TGT_W = 8 + SCALE_POW;
  localparam int unsigned CW    = ((TGT_W > THRESH_W) ? TGT_W : THRESH_W) + 1;

  localparam logic [THRESH_W-1:0] MIN_T  = THRESH_W'(MIN_THRESH);
  localparam logic [THRESH_W-1:0] MAX_T  = THRESH_W'(MAX_THRESH);
  localparam logic [THRESH_W-1:0] INIT_T = THRESH_W'(INIT_THRESH);
  localparam logic [CW-1:0]       MIN_C  = CW'(MIN_THRESH);
  localparam logic [CW-1:0]       MAX_C  = CW'(MAX_THRESH);
  localparam logic [CW-1:0]       STEP_C = CW'(STEP);
  localparam logic signed [CW:0]  MIN_S  = (CW+1)'(MIN_THRESH);
  localparam logic signed [CW:0]  MAX_S  = (CW+1)'(MAX_THRESH);
  localparam logic signed [CW:0]  BIAS_S = (CW+1)'(BIAS);

  typedef enum logic [1:0] {IDLE, MEASURE, UPDATE, APPLY} state_t;
  typedef enum logic [1:0] {BIAS_NONE, BIAS_UP, BIAS_DOWN} bias_t;

  state_t                state;
  bias_t                 pending;
  logic [WINDOW_POW-1:0] win_cnt;
  logic [7:0]            press_cnt;
  logic [7:0]            snap;
  logic [THRESH_W-1:0]   target;
  logic                  done_q;

  logic [7:0]            press_next;
  logic                  terminal;
  logic                  done_edge;
  bias_t                 bias_base;
  bias_t                 bias_next;
  logic [CW-1:0]         tgt_wide;
  logic [THRESH_W-1:0]   tgt_clamped;
  logic [THRESH_W-1:0]   manual_clamped;
  logic [CW-1:0]         thr_c;
  logic [CW-1:0]         tgt_c;
  logic [CW-1:0]         slew_diff;
  logic [CW-1:0]         slew_val;
  logic signed [CW:0]    biased;
  logic [THRESH_W-1:0]   apply_val;

  // Saturating press count, window terminal detect and round-outcome bias selection
  always_comb begin
    press_next = press_cnt;
    if (press && (press_cnt != 8'hFF))
      press_next = press_cnt + 8'd1;
    terminal  = (win_cnt == '1);
    done_edge = done && !done_q && (state != IDLE);
    // An outcome seen during APPLY belongs to the following window
    bias_base = (state == APPLY) ? BIAS_NONE : pending;
    bias_next = bias_base;
    if (done_edge) begin
      if (winner == 2'b10)
        bias_next = BIAS_UP;
      else if (winner == 2'b01)
        bias_next = BIAS_DOWN;
    end
  end

  // Press-derived target and manual value, both clamped into the legal range
  always_comb begin
    tgt_wide = CW'(snap) << SCALE_POW;
    if (tgt_wide < MIN_C)
      tgt_clamped = MIN_T;
    else if (tgt_wide > MAX_C)
      tgt_clamped = MAX_T;
    else
      tgt_clamped = tgt_wide[THRESH_W-1:0];

    if (manual_thresh < MIN_T)
      manual_clamped = MIN_T;
    else if (manual_thresh > MAX_T)
      manual_clamped = MAX_T;
    else
      manual_clamped = manual_thresh;
  end

  // Slew-limited move toward target, then signed bias add and final clamp
  always_comb begin
    thr_c     = CW'(threshold);
    tgt_c     = CW'(target);
    slew_diff = '0;
    slew_val  = thr_c;
    if (tgt_c > thr_c) begin
      slew_diff = tgt_c - thr_c;
      slew_val  = thr_c + ((slew_diff > STEP_C) ? STEP_C : slew_diff);
    end else if (tgt_c < thr_c) begin
      slew_diff = thr_c - tgt_c;
      slew_val  = thr_c - ((slew_diff > STEP_C) ? STEP_C : slew_diff);
    end

    biased = $signed({1'b0, slew_val});
    case (pending)
      BIAS_UP:   biased = biased + BIAS_S;
      BIAS_DOWN: biased = biased - BIAS_S;
      default:   biased = biased;
    endcase

    if (biased < MIN_S)
      apply_val = MIN_T;
    else if (biased > MAX_S)
      apply_val = MAX_T;
    else
      apply_val = biased[THRESH_W-1:0];
  end

  // Control FSM: measure window, compute target, apply slewed threshold
  always_ff @(posedge clk_game) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= BIAS_NONE;
      win_cnt    <= '0;
      press_cnt  <= '0;
      snap       <= '0;
      target     <= MIN_T;
      done_q     <= 1'b0;
      threshold  <= INIT_T;
      updated    <= 1'b0;
      last_count <= '0;
    end else begin
      done_q  <= done;
      updated <= 1'b0;
      if (manual_load) begin
        threshold <= manual_clamped;
        win_cnt   <= '0;
        press_cnt <= '0;
        pending   <= BIAS_NONE;
        updated   <= 1'b1;
        state     <= enable ? MEASURE : IDLE;
      end else if (!enable) begin
        win_cnt   <= '0;
        press_cnt <= '0;
        pending   <= BIAS_NONE;
        state     <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            win_cnt   <= '0;
            press_cnt <= '0;
            state     <= MEASURE;
          end
          MEASURE: begin
            pending <= bias_next;
            win_cnt <= win_cnt + 1'b1;
            if (terminal) begin
              snap      <= press_next;
              press_cnt <= '0;
              state     <= UPDATE;
            end else begin
              press_cnt <= press_next;
            end
          end
          UPDATE: begin
            pending    <= bias_next;
            target     <= tgt_clamped;
            last_count <= snap;
            press_cnt  <= press_next;
            state      <= APPLY;
          end
          APPLY: begin
            threshold <= apply_val;
            updated   <= 1'b1;
            pending   <= bias_next;
            win_cnt   <= '0;
            press_cnt <= press_next;
            state     <= MEASURE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cyber_threshold_tuner.sv
// Directed bench for cyber_threshold_tuner: a per-window vector table plus
// hand-written sequences for manual load, enable drop, reset and saturation.
module tb_cyber_threshold_tuner;

  localparam int NO = 99;

  logic       clk_game = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       press = 1'b0;
  logic       done = 1'b0;
  logic [1:0] winner = 2'b00;
  logic       manual_load = 1'b0;
  logic [9:0] manual_thresh = '0;
  logic [9:0] threshold;
  logic       updated;
  logic [7:0] last_count;

  logic       en10 = 1'b0;
  logic       press10 = 1'b0;
  logic       done10 = 1'b0;
  logic [1:0] winner10 = 2'b00;
  logic       ml10 = 1'b0;
  logic [9:0] mt10 = '0;
  logic [9:0] thr10;
  logic       upd10;
  logic [7:0] lc10;

  int checks = 0;
  int failures = 0;

  always #5 clk_game = ~clk_game;

  cyber_threshold_tuner #(.WINDOW_POW(4)) u_dut (
    .clk_game(clk_game), .reset(reset), .enable(enable), .press(press),
    .done(done), .winner(winner), .manual_load(manual_load),
    .manual_thresh(manual_thresh), .threshold(threshold),
    .updated(updated), .last_count(last_count)
  );

  cyber_threshold_tuner #(.WINDOW_POW(10)) u_dut_w10 (
    .clk_game(clk_game), .reset(reset), .enable(en10), .press(press10),
    .done(done10), .winner(winner10), .manual_load(ml10),
    .manual_thresh(mt10), .threshold(thr10),
    .updated(upd10), .last_count(lc10)
  );

  typedef struct {
    int         n;
    logic       pua;
    int         d1;
    logic [1:0] w1;
    int         d2;
    logic [1:0] w2;
    int         lc;
    int         thr;
  } vec_t;

  vec_t tbl [21];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One 18-cycle period: 16 MEASURE, UPDATE, APPLY; checks the write at its end
  task automatic run_window(input vec_t v, input string name);
    bit spurious = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk_game);
      press  = (i < v.n) || (v.pua && i >= 16);
      done   = (i == v.d1) || (i == v.d2);
      winner = (i == v.d2) ? v.w2 : v.w1;
      @(posedge clk_game); #1;
      if (i < 17 && updated) spurious = 1'b1;
    end
    check({name, "_upd"}, int'(updated), 1);
    check({name, "_early_upd"}, int'(spurious), 0);
    check({name, "_lc"}, int'(last_count), v.lc);
    check({name, "_thr"}, int'(threshold), v.thr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bit spurious;
    int cyc;

    tbl[0]  = '{16, 1'b0, NO, 2'b00, NO, 2'b00, 16, 128};
    tbl[1]  = '{0,  1'b0, NO, 2'b00, NO, 2'b00, 0,  112};
    tbl[2]  = '{0,  1'b0, NO, 2'b00, NO, 2'b00, 0,  96};
    tbl[3]  = '{16, 1'b0, 5,  2'b10, NO, 2'b00, 16, 144};
    tbl[4]  = '{16, 1'b0, 3,  2'b01, NO, 2'b00, 16, 96};
    tbl[5]  = '{10, 1'b0, NO, 2'b00, NO, 2'b00, 10, 80};
    tbl[6]  = '{11, 1'b0, NO, 2'b00, NO, 2'b00, 11, 88};
    tbl[7]  = '{16, 1'b0, 2,  2'b10, 9,  2'b01, 16, 72};
    tbl[8]  = '{8,  1'b1, 16, 2'b10, NO, 2'b00, 8,  96};
    tbl[9]  = '{12, 1'b0, 17, 2'b01, NO, 2'b00, 14, 112};
    tbl[10] = '{16, 1'b0, NO, 2'b00, NO, 2'b00, 16, 96};
    tbl[11] = '{16, 1'b0, 4,  2'b11, NO, 2'b00, 16, 112};
    tbl[12] = '{0,  1'b0, NO, 2'b00, NO, 2'b00, 0,  96};
    tbl[13] = '{0,  1'b0, NO, 2'b00, NO, 2'b00, 0,  80};
    tbl[14] = '{0,  1'b0, NO, 2'b00, NO, 2'b00, 0,  64};
    tbl[15] = '{0,  1'b0, NO, 2'b00, NO, 2'b00, 0,  48};
    tbl[16] = '{0,  1'b0, NO, 2'b00, NO, 2'b00, 0,  32};
    tbl[17] = '{0,  1'b0, NO, 2'b00, NO, 2'b00, 0,  16};
    tbl[18] = '{0,  1'b0, NO, 2'b00, NO, 2'b00, 0,  16};
    tbl[19] = '{0,  1'b0, 6,  2'b01, NO, 2'b00, 0,  16};
    tbl[20] = '{0,  1'b0, 6,  2'b10, NO, 2'b00, 0,  48};

    // Reset state
    repeat (3) @(posedge clk_game);
    #1;
    check("rst_thr", int'(threshold), 128);
    check("rst_upd", int'(updated), 0);
    check("rst_lc", int'(last_count), 0);

    @(negedge clk_game);
    reset  = 1'b0;
    enable = 1'b1;

    for (int k = 0; k < 21; k++)
      run_window(tbl[k], $sformatf("win%0d", k));
    press = 1'b0;
    done  = 1'b0;

    // Manual load clamps at both ends
    @(negedge clk_game);
    manual_load = 1'b1; manual_thresh = 10'd600;
    @(posedge clk_game); #1;
    check("ml600_thr", int'(threshold), 511);
    check("ml600_upd", int'(updated), 1);
    @(negedge clk_game);
    manual_thresh = 10'd5;
    @(posedge clk_game); #1;
    check("ml5_thr", int'(threshold), 16);
    check("ml5_upd", int'(updated), 1);
    manual_load = 1'b0;

    v = '{16, 1'b0, 5, 2'b10, NO, 2'b00, 16, 64};
    run_window(v, "after_ml5");

    @(negedge clk_game);
    manual_load = 1'b1; manual_thresh = 10'd600;
    @(posedge clk_game); #1;
    check("ml600b_thr", int'(threshold), 511);
    manual_load = 1'b0;
    v = '{16, 1'b0, 5, 2'b10, NO, 2'b00, 16, 511};
    run_window(v, "bias_top_clamp");

    // Manual load wins over enable low
    @(negedge clk_game);
    press = 1'b0; done = 1'b0;
    enable = 1'b0; manual_load = 1'b1; manual_thresh = 10'd300;
    @(posedge clk_game); #1;
    check("ml300_thr", int'(threshold), 300);
    check("ml300_upd", int'(updated), 1);
    manual_load = 1'b0;

    // Enable dropped mid-window with pending +BIAS and 10 presses
    @(negedge clk_game);
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_game);
      press  = (i < 10);
      done   = (i == 3);
      winner = 2'b10;
    end
    @(negedge clk_game);
    enable = 1'b0; press = 1'b0; done = 1'b0;
    spurious = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk_game);
      done = (j == 5);
      @(posedge clk_game); #1;
      if (updated) spurious = 1'b1;
    end
    check("dis_no_upd", int'(spurious), 0);
    check("dis_thr", int'(threshold), 300);
    check("dis_lc", int'(last_count), 16);
    @(negedge clk_game);
    enable = 1'b1; done = 1'b0;
    v = '{4, 1'b0, NO, 2'b00, NO, 2'b00, 4, 284};
    run_window(v, "reenable");

    // Reset mid-window drops everything
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_game);
      press  = 1'b1;
      done   = (i == 2);
      winner = 2'b10;
    end
    @(negedge clk_game);
    reset = 1'b1; press = 1'b0; done = 1'b0;
    @(posedge clk_game); #1;
    check("midrst_thr", int'(threshold), 128);
    check("midrst_lc", int'(last_count), 0);
    check("midrst_upd", int'(updated), 0);
    @(negedge clk_game);
    reset = 1'b0;
    v = '{16, 1'b0, NO, 2'b00, NO, 2'b00, 16, 128};
    run_window(v, "post_rst");
    press = 1'b0;

    // Full-length window with press held high: counter saturation, target clamp
    @(negedge clk_game);
    en10 = 1'b1; press10 = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 1100; c++) begin
      @(posedge clk_game); #1;
      if (upd10) begin
        cyc = c;
        break;
      end
    end
    check("w10_latency", cyc, 1027);
    check("w10_lc", int'(lc10), 255);
    check("w10_thr", int'(thr10), 144);
    en10 = 1'b0; press10 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
